// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit feeding the IF/ID register
// Optional misaligned-jump fault checking: FETCH_MISALIGN_CHK_EN
module ifu_fetch #(
  parameter logic [31:0] RST_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        jmp_en_i,
  input  logic [31:0] jmp_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HELD
`ifdef FETCH_MISALIGN_CHK_EN
    , S_FAULT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        req;
  logic        present_nop;
  logic        outstanding;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_q, misalign_d;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    req         = 1'b0;
    present_nop = 1'b0;
    outstanding = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d  = misalign_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        req         = 1'b1;
        present_nop = !hold_i;
        if (ibus_gnt_i) begin
          state_d    = S_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (ibus_rvalid_i) begin
          if (kill_q) begin
            kill_d      = 1'b0;
            state_d     = S_REQ;
            present_nop = !hold_i;
          end else if (hold_i) begin
            skid_pc_d   = req_pc_q;
            skid_inst_d = ibus_rdata_i;
            state_d     = S_HELD;
          end else begin
            // Present the response and issue the next request in the same cycle.
            pc_d    = req_pc_q;
            inst_d  = ibus_rdata_i;
            valid_d = 1'b1;
            req     = 1'b1;
            if (ibus_gnt_i) begin
              req_pc_d   = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
              state_d = S_REQ;
            end
          end
        end else begin
          present_nop = !hold_i;
        end
      end
      S_HELD: begin
        if (!hold_i) begin
          pc_d    = skid_pc_q;
          inst_d  = skid_inst_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = state_q;
    endcase

    if (present_nop) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end

    if (jmp_en_i) begin
      // A response still owed by the bus after this cycle must be discarded.
      outstanding = (state_q == S_WAIT && !ibus_rvalid_i) || (req && ibus_gnt_i);
      fetch_pc_d  = jmp_addr_i & ~32'd3;
      pc_d        = pc_q;
      inst_d      = NOP_INST;
      valid_d     = 1'b0;
      kill_d      = outstanding;
      state_d     = outstanding ? S_WAIT : S_REQ;
`ifdef FETCH_MISALIGN_CHK_EN
      if (jmp_addr_i[1:0] != 2'b00) begin
        state_d    = S_FAULT;
        kill_d     = 1'b0;
        misalign_d = 1'b1;
        pc_d       = jmp_addr_i;
      end else begin
        misalign_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RST_PC;
      req_pc_q    <= RST_PC;
      kill_q      <= 1'b0;
      skid_pc_q   <= RST_PC;
      skid_inst_q <= NOP_INST;
      pc_q        <= RST_PC;
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

  assign ibus_req_o  = req;
  assign ibus_addr_o = fetch_pc_q;
  assign pc_o        = pc_q;
  assign inst_o      = inst_q;
  assign valid_o     = valid_q;
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_o  = misalign_q;
`else
  assign misalign_o  = 1'b0;
`endif

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: generates the program counter, fetches instructions over the instruction bus, and drives the `pc`/`inst` inputs of the IF/ID pipeline register. It is the producer side of the IF→ID interface. It obeys the same `hold_i`/`jmp_en_i` controls as the pipeline register and substitutes NOP whenever it has no valid instruction to present. One request is outstanding at most; back-to-back issue gives one instruction per cycle on a zero-wait bus.

## Interface
- `RST_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INST`, default `32'h0000_0013`: instruction presented when no valid fetch (`addi x0,x0,0`).

- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `hold_i` input 1: downstream stall; freezes presented outputs.
- `jmp_en_i` input 1: redirect pulse from execute.
- `jmp_addr_i` input 32: redirect target.
- `ibus_req_o` output 1: bus request.
- `ibus_addr_o` output 32: request address; word aligned.
- `ibus_gnt_i` input 1: request accepted in the same cycle as `req`.
- `ibus_rvalid_i` input 1: response valid; earliest one cycle after the grant.
- `ibus_rdata_i` input 32: response data.
- `pc_o` output 32: PC of the presented instruction.
- `inst_o` output 32: presented instruction.
- `valid_o` output 1: `inst_o` is a real fetched instruction.
- `misalign_o` output 1: sticky misaligned-jump fault (see Configuration).

## Operation
- States:
  - IDLE: reset only.
  - REQ: `req=1`, waiting for a grant.
  - WAIT: one request outstanding.
  - HELD: response captured in the skid buffer while `hold_i=1`.
  - FAULT: macro only.
- Internal registers:
  - `fetch_pc`: address of the next request.
  - `kill`: discard the outstanding response.
  - `skid_pc` / `skid_inst`.
- IDLE → REQ unconditionally.
- REQ: `ibus_addr_o=fetch_pc`.
  - On `gnt`: go to WAIT and advance `fetch_pc += 4`. The add wraps modulo 2^32.
  - The address may change before a grant; the bus allows this.
- WAIT, on `rvalid` with `kill=0`:
  - `hold_i=0`: register {`pc`, `rdata`} to the outputs with `valid_o=1`. In the same cycle, assert `req` with `fetch_pc`. Go to REQ, or stay in WAIT if granted.
  - `hold_i=1`: capture into skid, go to HELD, `req=0`.
- WAIT, on `rvalid` with `kill=1`: drop the data, clear `kill`, go to REQ.
- WAIT without `rvalid`, `hold_i=0`: outputs become `NOP_INST` with `valid_o=0`. `pc_o` holds its value.
- HELD: outputs frozen. On the first cycle with `hold_i=0`, move skid to the outputs with `valid_o=1` and go to REQ.
- `hold_i=1` in any state freezes `pc_o`/`inst_o`/`valid_o`. Fetching continues until a response needs the skid buffer.
- `jmp_en_i=1` has priority over everything, including `hold_i`:
  - `fetch_pc ← {jmp_addr_i[31:2],2'b00}`.
  - Outputs: `inst_o=NOP_INST`, `valid_o=0`, `pc_o` unchanged.
  - Skid buffer discarded.
  - In WAIT, or in REQ with `gnt` the same cycle: set `kill`, go to WAIT.
  - Otherwise go to REQ. A REQ at the new address is issued the cycle after the jump; a same-cycle `req` still uses the old address.
  - If `rvalid` arrives in the jump cycle, the data is dropped.
- Reset mid-operation: every register returns to its reset value. An outstanding bus response arriving after reset is ignored (state IDLE/REQ ignores `rvalid`).

## Timing
- Reset values:
  - `pc_o=RST_PC`, `inst_o=NOP_INST`, `valid_o=0`, `misalign_o=0`.
  - `ibus_req_o=0`, `ibus_addr_o=RST_PC`.
  - State IDLE; `kill=0`.
- First `req` appears in the first cycle after `rst_n` rises.
- Latency: `gnt` in cycle n, `rvalid` in n+k (k≥1); `inst_o` is valid from cycle n+k+1.
- Zero-wait bus: sustained throughput of 1 instruction/cycle.
- Jump in cycle j: first request at the target in cycle j+1. With no kill pending, the target instruction appears at j+3 on a zero-wait bus.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - A jump with `jmp_addr_i[1:0]!=0` goes to FAULT: `req=0`, NOP outputs, `misalign_o=1`, and `pc_o=jmp_addr_i` (the faulting target).
  - FAULT is left only by an aligned jump, which clears `misalign_o` and proceeds normally.
- Undefined: `jmp_addr_i[1:0]` is ignored (forced to 0), `misalign_o` is tied to 0, and there is no FAULT state.

## Test plan
- Reset, then a zero-wait bus (gnt=1, rvalid next cycle), memory word = address: `pc_o` = 0, 4, 8, ... on consecutive cycles from cycle 3, with `inst_o == pc_o` and `valid_o=1`.
- `hold_i=1` for 3 cycles while the response for 0x8 arrives: outputs stay at 0x4, `req=0`. Hold drops: `pc_o=0x8`, `inst_o=0x8`, then the fetch of 0xC.
- `jmp_en_i` with `jmp_addr_i=0x100` while a request is in WAIT (`rvalid` 2 cycles later): the stale response is dropped. The next `ibus_addr_o=0x100`, and the next valid `pc_o=0x100`.
- Jump in the same cycle as `rvalid` and `hold_i=1`: `inst_o=0x13`, `valid_o=0`, and the following fetch is from the target.
- `pc_o` reaches `0xFFFF_FFFC`: the next `ibus_addr_o` is `0x0000_0000`.
- With `FETCH_MISALIGN_CHK_EN`, jump to 0x102: `misalign_o=1`, `req` stays 0 for 10 cycles. Then a jump to 0x200: `misalign_o=0` and a fetch from 0x200. Without the macro, the same jump fetches 0x100.
